// File: rtl/pe_pkg.sv
// Shared FP32 field layout, special encodings and PE defaults for the PE array.
// Also holds the common round/pack step used by the multiplier and the adder.
package pe_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  localparam int PE_L_RAM_SIZE = 6;
  localparam int PE_MAC_LAT    = 4;

  typedef struct packed {
    logic [FP_SIGN_W-1:0] sign;
    logic [FP_EXP_W-1:0]  expo;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  // Round-to-nearest-even on a 24-bit mantissa (hidden bit included), then
  // saturate to inf or flush to signed zero when the exponent leaves range.
  function automatic logic [31:0] fp_round_pack(input logic              sign,
                                                input logic signed [9:0] expo,
                                                input logic [23:0]       mant,
                                                input logic              guard,
                                                input logic              sticky);
    logic [24:0]       m;
    logic signed [9:0] e;
    m = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    e = expo;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {sign, FP_POS_INF[30:0]};
    else if (e <= 10'sd0)
      return {sign, 31'd0};
    else
      return {sign, e[7:0], 23'(m)};
  endfunction

endpackage

// File: rtl/fp32_mac.sv
// Serial fp32 multiply-accumulate: latch operands, multiply and round, then add
// and round; a valid shift register times completion at exactly LAT cycles.
module fp32_mac
  import pe_pkg::*;
#(
  parameter int LAT = PE_MAC_LAT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] a_i,
  input  logic [31:0] w_i,
  input  logic [31:0] acc_i,
  output logic        out_valid_o,
  output logic        busy_o,
  output logic [31:0] result_o
);

  function automatic logic is_zero(input fp32_t v);
    return v.expo == '0;
  endfunction

  function automatic logic is_inf(input fp32_t v);
    return (v.expo == '1) && (v.frac == '0);
  endfunction

  function automatic logic is_nan(input fp32_t v);
    return (v.expo == '1) && (v.frac != '0);
  endfunction

  function automatic logic [31:0] fp_mul(input fp32_t a, input fp32_t b);
    logic              sign;
    logic [47:0]       p;
    logic signed [9:0] e;
    sign = a.sign ^ b.sign;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
      return FP_QNAN;
    else if (is_inf(a) || is_inf(b))
      return {sign, FP_POS_INF[30:0]};
    else if (is_zero(a) || is_zero(b))
      return {sign, 31'd0};
    p = {24'd0, 1'b1, a.frac} * {24'd0, 1'b1, b.frac};
    e = signed'({2'b00, a.expo}) + signed'({2'b00, b.expo}) - signed'(10'(FP_BIAS));
    if (p[47])
      return fp_round_pack(sign, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    else
      return fp_round_pack(sign, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input fp32_t a, input fp32_t b);
    fp32_t             x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my, n;
    logic [53:0]       sh;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic              found;
    logic signed [9:0] e;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a.sign != b.sign)))
      return FP_QNAN;
    else if (is_inf(a))
      return {a.sign, FP_POS_INF[30:0]};
    else if (is_inf(b))
      return {b.sign, FP_POS_INF[30:0]};
    else if (is_zero(a) && is_zero(b))
      return {a.sign & b.sign, 31'd0};
    else if (is_zero(a))
      return b;
    else if (is_zero(b))
      return a;
    if ({a.expo, a.frac} >= {b.expo, b.frac}) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // 3 extra low bits act as guard/round/sticky through alignment
    d  = x.expo - y.expo;
    mx = {1'b1, x.frac, 3'b000};
    sh = {1'b1, y.frac, 3'b000, 27'd0} >> d;
    my = sh[53:27] | {26'd0, |sh[26:0]};
    if (x.sign == y.sign)
      s = {1'b0, mx} + {1'b0, my};
    else
      s = {1'b0, mx} - {1'b0, my};
    if (s == '0)
      return FP_ZERO;
    e = signed'({2'b00, x.expo});
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      lz    = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else      lz = lz + 5'd1;
        end
      end
      n = s[26:0] << lz;
      e = e - signed'({5'd0, lz});
    end
    return fp_round_pack(x.sign, e, n[26:3], n[2], |n[1:0]);
  endfunction

  logic [31:0]    a_q, w_q, acc_q, prod_q, prod_d;
  logic [LAT-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= {vld_q[LAT-2:0], in_valid_i};
  end

  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      a_q   <= a_i;
      w_q   <= w_i;
      acc_q <= acc_i;
    end
    if (vld_q[0]) prod_q <= prod_d;
  end

  always_comb begin
    prod_d   = fp_mul(fp32_t'(a_q), fp32_t'(w_q));
    result_o = fp_add(fp32_t'(prod_q), fp32_t'(acc_q));
  end

  assign out_valid_o = vld_q[LAT-1];
  assign busy_o      = |vld_q;

endmodule

// File: rtl/my_pe.sv
// Matrix-multiply PE leaf: serially loaded local weight RAM feeding an fp32 MAC
// whose running sum is held in dout until the next completion or reset.
module my_pe
  import pe_pkg::*;
#(
  parameter int L_RAM_SIZE = PE_L_RAM_SIZE,
  parameter int MAC_LAT    = PE_MAC_LAT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           ain,
  input  logic [31:0]           din,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic                  we,
  input  logic                  valid,
  output logic                  dvalid,
  output logic [31:0]           dout
);

  logic [31:0] peram [0:(1<<L_RAM_SIZE)-1];
  logic        accept, busy, mac_done;
  logic [31:0] mac_result;
  logic [31:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;

  // A write wins over valid on the same edge; valid while busy is dropped.
  assign accept = valid & ~we & ~busy;

  always_ff @(posedge aclk) begin
    if (we) peram[addr] <= din;
  end

  fp32_mac #(.LAT(MAC_LAT)) u_mac (
    .clk_i       (aclk),
    .rst_i       (aresetn),
    .in_valid_i  (accept),
    .a_i         (ain),
    .w_i         (peram[addr]),
    .acc_i       (dout_q),
    .out_valid_o (mac_done),
    .busy_o      (busy),
    .result_o    (mac_result)
  );

  always_comb begin
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (mac_done) begin
      dout_d   = mac_result;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      dout_q   <= FP_ZERO;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: tb/tb_my_pe.sv
// Directed bench for my_pe: load/MAC, accumulation, busy and priority rules,
// FP special cases, rounding, reset behaviour and a 16-op integer golden run.
module tb_my_pe;

  localparam int L   = 6;
  localparam int LAT = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   ain, din;
  logic [L-1:0]  addr;
  logic          we, valid;
  logic          dvalid;
  logic [31:0]   dout;

  int checks = 0;
  int errors = 0;
  int pulses, p1, p2, acc;
  logic [31:0] d1;

  always #5 aclk = ~aclk;

  my_pe #(.L_RAM_SIZE(L), .MAC_LAT(LAT)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .ain     (ain),
    .din     (din),
    .addr    (addr),
    .we      (we),
    .valid   (valid),
    .dvalid  (dvalid),
    .dout    (dout)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b1;
    repeat (n) tick();
    aresetn = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we   = 1'b1;
    addr = a[L-1:0];
    din  = d;
    tick();
    we   = 1'b0;
  endtask

  task automatic mac(input string tag, input int a, input logic [31:0] x, input logic [31:0] expv);
    int first, cnt;
    valid = 1'b1;
    ain   = x;
    addr  = a[L-1:0];
    tick();
    valid = 1'b0;
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      if (dvalid) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check({tag, " latency"}, 32'(first), 32'(LAT));
    check({tag, " pulses"}, 32'(cnt), 32'd1);
    check({tag, " dout"}, dout, expv);
  endtask

  // exact fp32 encoding of a small integer (|v| < 2^24)
  function automatic logic [31:0] i2f(input int v);
    int          m, p;
    logic        s;
    logic [31:0] mm;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    mm = 32'(m) << (23 - p);
    return {s, 8'(127 + p), mm[22:0]};
  endfunction

  initial begin
    aresetn = 1'b1;
    ain = '0; din = '0; addr = '0; we = 1'b0; valid = 1'b0;

    do_reset(2);
    check("reset dout", dout, 32'h0);
    check("reset dvalid", {31'd0, dvalid}, 32'd0);

    wr(0, 32'h4000_0000);
    mac("mac 3x2", 0, 32'h4040_0000, 32'h40C0_0000);
    wr(1, 32'h3F80_0000);
    mac("acc 2x1", 1, 32'h4000_0000, 32'h4100_0000);

    // valid re-pulsed while busy must be ignored
    valid = 1'b1; ain = 32'h3F80_0000; addr = 1; tick();
    ain = 32'h4000_0000; addr = 0; tick();
    valid = 1'b0;
    pulses = dvalid ? 1 : 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (dvalid) pulses++;
    end
    check("busy pulses", 32'(pulses), 32'd1);
    check("busy dout", dout, 32'h4110_0000);

    // level valid: second op accepted on the edge after completion
    valid = 1'b1; ain = 32'h3F80_0000; addr = 1; tick();
    p1 = -1; p2 = -1; pulses = 0; d1 = '0;
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      tick();
      if (k == LAT + 1) valid = 1'b0;
      if (dvalid) begin
        pulses++;
        if (p1 < 0) begin p1 = k; d1 = dout; end
        else if (p2 < 0) p2 = k;
      end
    end
    check("level pulses", 32'(pulses), 32'd2);
    check("level first at", 32'(p1), 32'(LAT));
    check("level first dout", d1, 32'h4120_0000);
    check("level second at", 32'(p2), 32'(2 * LAT + 1));
    check("level second dout", dout, 32'h4130_0000);

    // we and valid together: write only
    we = 1'b1; valid = 1'b1; addr = 2; din = 32'h4080_0000; ain = 32'h3F80_0000; tick();
    we = 1'b0; valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      if (dvalid) pulses++;
    end
    check("we+valid pulses", 32'(pulses), 32'd0);
    check("we+valid dout", dout, 32'h4130_0000);
    mac("we+valid ram", 2, 32'h3F80_0000, 32'h4170_0000);

    wr(3, 32'h40A0_0000);
    mac("read after write", 3, 32'h3F80_0000, 32'h41A0_0000);
    mac("denormal ain", 0, 32'h0000_0001, 32'h41A0_0000);

    do_reset(2);
    check("reset2 dout", dout, 32'h0);
    check("reset2 dvalid", {31'd0, dvalid}, 32'd0);
    mac("ram retained", 3, 32'h3F80_0000, 32'h40A0_0000);

    // reset one cycle after acceptance drops the op
    valid = 1'b1; ain = 32'h4040_0000; addr = 0; tick();
    valid = 1'b0; aresetn = 1'b1; tick();
    aresetn = 1'b0;
    pulses = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      if (dvalid) pulses++;
    end
    check("midreset pulses", 32'(pulses), 32'd0);
    check("midreset dout", dout, 32'h0);
    mac("after midreset", 0, 32'h4040_0000, 32'h40C0_0000);

    do_reset(1);
    wr(4, 32'h3F80_0000);
    mac("rnd mul exact", 4, 32'h3F80_0001, 32'h3F80_0001);
    wr(5, 32'h3380_0000);
    mac("rnd add tie odd", 5, 32'h3F80_0000, 32'h3F80_0002);
    wr(6, 32'h3F80_0001);
    mac("rnd mul sticky", 6, 32'h3F80_0001, 32'h4000_0002);
    wr(7, 32'h4000_0002);
    mac("exact cancel", 7, 32'hBF80_0000, 32'h0000_0000);

    do_reset(1);
    for (int i = 0; i < 16; i++) wr(i, i2f(i + 1));
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + (i - 7) * (i + 1);
      mac($sformatf("golden op%0d", i), i, i2f(i - 7), i2f(acc));
    end

    mac("overflow", 1, 32'h7F00_0000, 32'h7F80_0000);
    wr(9, 32'h0000_0000);
    mac("inf times zero", 9, 32'h7F80_0000, 32'h7FC0_0000);

    do_reset(1);
    mac("pos inf", 1, 32'h7F00_0000, 32'h7F80_0000);
    mac("inf minus inf", 1, 32'hFF00_0000, 32'h7FC0_0000);

    do_reset(1);
    mac("nan input", 0, 32'h7FC1_2345, 32'h7FC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
